// File: rtl/fpu_rr_scheduler_pkg.sv
// Shared FPU format constants and types for the FPU scheduler and the FPU itself.
package fpu_rr_scheduler_pkg;

    localparam int FP_W            = 32;
    localparam int EXP_W           = 6;
    localparam int MANT_W          = 25;
    localparam int EXP_BIAS        = 31;
    localparam int STATUS_W        = 4;
    localparam int FPU_PASS_CYCLES = 5;
    // Two full FPU passes plus one edge guarantee a result computed from held operands.
    localparam int MIN_HOLD_CYCLES = 2 * FPU_PASS_CYCLES + 1;

    typedef enum logic [STATUS_W-1:0] {
        ST_EXACT     = 4'b0001,
        ST_INEXACT   = 4'b0010,
        ST_OVERFLOW  = 4'b0100,
        ST_UNDERFLOW = 4'b1000
    } status_out_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_RESPOND = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fpu_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic found;
    int   pos;

    // Scan ptr, ptr+1, ... wrapping at N; the first set request takes the grant.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!found && req[IDX_W'(pos)]) begin
                grant[IDX_W'(pos)] = 1'b1;
                index              = IDX_W'(pos);
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Round-robin scheduler sharing one free-running FPU among N_REQ clients.
// Holds operands for HOLD_CYCLES edges, captures the FPU result and returns it
// tagged with the requester index.
module fpu_rr_scheduler
    import fpu_rr_scheduler_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 11,
    parameter int ID_W        = 2
) (
    input  logic                     clock100KHz,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [32*N_REQ-1:0]      req_op_a,
    input  logic [32*N_REQ-1:0]      req_op_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [3:0]               rsp_status,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_err,
    output logic [31:0]              fpu_op_a,
    output logic [31:0]              fpu_op_b,
    input  logic [31:0]              fpu_data_in,
    input  logic [3:0]               fpu_status_in,
    output logic                     busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    sched_state_t     state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] arb_idx;
    logic [N_REQ-1:0] arb_grant;
    logic [CNT_W-1:0] cnt;
    logic [FP_W-1:0]  op_a_arr [N_REQ];
    logic [FP_W-1:0]  op_b_arr [N_REQ];

    // Unpack the flat operand buses so the winner can be selected by index.
    for (genvar g = 0; g < N_REQ; g++) begin : g_ops
        assign op_a_arr[g] = req_op_a[FP_W*g +: FP_W];
        assign op_b_arr[g] = req_op_b[FP_W*g +: FP_W];
    end

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_idx)
    );

    // Scheduler FSM: grant, hold operands across two FPU passes, present result.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            req_ready  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            busy       <= 1'b0;
        end else begin
            req_ready <= '0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        fpu_op_a  <= op_a_arr[arb_idx];
                        fpu_op_b  <= op_b_arr[arb_idx];
                        req_ready <= arb_grant;
                        rsp_id    <= ID_W'(arb_idx);
                        cnt       <= CNT_W'(HOLD_CYCLES - 1);
                        rr_ptr    <= (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
                        busy      <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        rsp_data   <= fpu_data_in;
                        rsp_status <= fpu_status_in;
                        rsp_err    <= ~$onehot(fpu_status_in);
                        rsp_valid  <= 1'b1;
                        state      <= S_RESPOND;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Bench for fpu_rr_scheduler: behavioural FPU stub, a job-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fpu_rr_scheduler;
    import fpu_rr_scheduler_pkg::*;

    localparam int N    = 4;
    localparam int HOLD = 11;
    localparam int IDW  = 2;

    logic            clock100KHz = 1'b0;
    logic            reset       = 1'b0;
    logic [N-1:0]    req_valid   = '0;
    logic [32*N-1:0] req_op_a    = '0;
    logic [32*N-1:0] req_op_b    = '0;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready   = 1'b1;
    logic [31:0]     rsp_data;
    logic [3:0]      rsp_status;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_err;
    logic [31:0]     fpu_op_a, fpu_op_b;
    logic [31:0]     fpu_data_in   = '0;
    logic [3:0]      fpu_status_in = '0;
    logic            busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    fpu_rr_scheduler #(.N_REQ(N), .HOLD_CYCLES(HOLD), .ID_W(IDW)) dut (
        .clock100KHz   (clock100KHz),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op_a      (req_op_a),
        .req_op_b      (req_op_b),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .rsp_id        (rsp_id),
        .rsp_err       (rsp_err),
        .fpu_op_a      (fpu_op_a),
        .fpu_op_b      (fpu_op_b),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .busy          (busy)
    );

    always #5 clock100KHz = ~clock100KHz;

    // Reference FP add, valid for positive operands with equal exponents.
    function automatic logic [31:0] ref_data(input logic [31:0] a, input logic [31:0] b);
        logic [26:0] s;
        logic [6:0]  e;
        s = {2'b01, a[24:0]} + {2'b01, b[24:0]};
        e = {1'b0, a[30:25]} + 7'd1;
        return {1'b0, e[5:0], s[25:1]};
    endfunction

    function automatic logic [3:0] ref_status(input logic [31:0] a, input logic [31:0] b);
        logic [26:0] s;
        logic [6:0]  e;
        s = {2'b01, a[24:0]} + {2'b01, b[24:0]};
        e = {1'b0, a[30:25]} + 7'd1;
        if (e[6])      return ST_OVERFLOW;
        else if (s[0]) return ST_INEXACT;
        else           return ST_EXACT;
    endfunction

    // FPU stub: free-running 5-state pass, samples inputs at pass start, publishes at pass end.
    int          pass_cnt  = 0;
    logic [31:0] lat_a     = '0;
    logic [31:0] lat_b     = '0;
    bit          force_bad = 1'b0;
    always @(posedge clock100KHz) begin
        if (pass_cnt == 0) begin
            lat_a <= fpu_op_a;
            lat_b <= fpu_op_b;
        end
        if (pass_cnt == FPU_PASS_CYCLES - 1) begin
            fpu_data_in   <= ref_data(lat_a, lat_b);
            fpu_status_in <= force_bad ? 4'b0011 : ref_status(lat_a, lat_b);
        end
        pass_cnt <= (pass_cnt == FPU_PASS_CYCLES - 1) ? 0 : pass_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Job-level model: a job accepted at some edge yields its result HOLD edges later
    // and stays on the output until the consumer takes it.
    bit          job_on = 0, rsp_on = 0;
    int          ticks = 0, m_ptr = 0, w = 0, c = 0;
    logic [N-1:0] e_ready = '0;
    logic        e_valid = 0, e_err = 0, e_busy = 0;
    logic [31:0] e_data = '0, e_opa = '0, e_opb = '0;
    logic [3:0]  e_status = '0;
    logic [IDW-1:0] e_id = '0;
    always @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            job_on = 0; rsp_on = 0; ticks = 0; m_ptr = 0;
            e_ready = '0; e_valid = 0; e_err = 0; e_busy = 0;
            e_data = '0; e_status = '0; e_id = '0; e_opa = '0; e_opb = '0;
        end else begin
            e_ready = '0;
            if (rsp_on) begin
                if (rsp_ready) begin
                    rsp_on = 0; e_valid = 0; e_err = 0;
                end
            end else if (job_on) begin
                ticks--;
                if (ticks == 0) begin
                    job_on   = 0;
                    rsp_on   = 1;
                    e_valid  = 1;
                    e_data   = ref_data(e_opa, e_opb);
                    e_status = force_bad ? 4'b0011 : ref_status(e_opa, e_opb);
                    e_err    = ($countones(e_status) != 1);
                end
            end else if (req_valid != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (w < 0 && req_valid[c]) w = c;
                end
                e_ready[w] = 1'b1;
                e_id       = IDW'(w);
                e_opa      = req_op_a[32*w +: 32];
                e_opb      = req_op_b[32*w +: 32];
                m_ptr      = (w + 1) % N;
                ticks      = HOLD;
                job_on     = 1;
            end
            e_busy = job_on || rsp_on;
        end
    end

    // Per-cycle compare against the model, plus event bookkeeping for directed checks.
    int  rise_cnt = 0, g2_cnt = 0, id2_cnt = 0;
    bit  prev_valid = 0;
    always @(posedge clock100KHz) begin
        cyc++;
        #1;
        check("m_req_ready", 32'(req_ready), 32'(e_ready));
        check("m_rsp_valid", 32'(rsp_valid), 32'(e_valid));
        check("m_rsp_data", rsp_data, e_data);
        check("m_rsp_status", 32'(rsp_status), 32'(e_status));
        check("m_rsp_id", 32'(rsp_id), 32'(e_id));
        check("m_rsp_err", 32'(rsp_err), 32'(e_err));
        check("m_fpu_op_a", fpu_op_a, e_opa);
        check("m_fpu_op_b", fpu_op_b, e_opb);
        check("m_busy", 32'(busy), 32'(e_busy));
        if (rsp_valid && !prev_valid) rise_cnt++;
        prev_valid = rsp_valid;
        if (req_ready[2]) g2_cnt++;
        if (rsp_valid && rsp_id == 2'd2) id2_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock100KHz);
    endtask

    task automatic wait_grant(output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock100KHz);
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                at = cyc;
                return;
            end
        end
        check("grant_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock100KHz);
            if (rsp_valid) begin
                at = cyc;
                return;
            end
        end
        check("rsp_timeout", 32'd1, 32'd0);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int g, gc, rc, rel, r0;
    int gidx [5];
    int gcyc [5];
    logic [31:0] s_data;
    logic [3:0]  s_status;
    logic [IDW-1:0] s_id;

    initial begin
        // Test 1: reset state, then reset in the middle of a hold window.
        tick(2);
        check("t1_reset_busy", 32'(busy), 32'd0);
        check("t1_reset_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        tick(1);
        req_op_a[31:0] = 32'h3E000000;
        req_op_b[31:0] = 32'h3E000000;
        req_valid[0]   = 1'b1;
        wait_grant(g, gc);
        req_valid[0] = 1'b0;
        tick(4);
        check("t1_busy_mid_hold", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("t1_async_busy", 32'(busy), 32'd0);
        check("t1_async_fpu_a", fpu_op_a, 32'd0);
        check("t1_async_rsp_id", 32'(rsp_id), 32'd0);
        tick(1);
        reset = 1'b1;
        r0 = rise_cnt;
        tick(20);
        check("t1_no_rsp_after_abort", 32'(rise_cnt - r0), 32'd0);

        // Test 2: 1.0 + 1.0 from requester 0, latency and literal result.
        rsp_ready    = 1'b0;
        req_valid[0] = 1'b1;
        wait_grant(g, gc);
        req_valid[0] = 1'b0;
        check("t2_grant_idx", 32'(g), 32'd0);
        wait_rsp(rc);
        check("t2_latency", 32'(rc - gc), 32'd11);
        check("t2_data", rsp_data, 32'h40000000);
        check("t2_status", 32'(rsp_status), 32'b0001);
        check("t2_id", 32'(rsp_id), 32'd0);
        check("t2_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        tick(1);
        check("t2_valid_cleared", 32'(rsp_valid), 32'd0);
        tick(2);

        // Test 3: all four requesting continuously.
        reset_pulse();
        for (int i = 0; i < N; i++) begin
            req_op_a[32*i +: 32] = 32'h3E000000 | (32'(i) << 22);
            req_op_b[32*i +: 32] = 32'h3E000000 | 32'(i);
        end
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            wait_grant(gidx[j], gcyc[j]);
        end
        req_valid = '0;
        check("t3_order0", 32'(gidx[0]), 32'd0);
        check("t3_order1", 32'(gidx[1]), 32'd1);
        check("t3_order2", 32'(gidx[2]), 32'd2);
        check("t3_order3", 32'(gidx[3]), 32'd3);
        check("t3_order4", 32'(gidx[4]), 32'd0);
        for (int j = 1; j < 5; j++) check("t3_spacing", 32'(gcyc[j] - gcyc[j-1]), 32'd13);
        tick(16);

        // Test 4: consumer stalls; result stays put, no new grant until release.
        rsp_ready = 1'b0;
        req_op_a[63:32] = 32'h3F000000;
        req_op_b[63:32] = 32'h3E000000;
        req_valid = 4'b0011;
        wait_grant(g, gc);
        req_valid[1] = 1'b0;
        check("t4_grant_idx", 32'(g), 32'd1);
        wait_rsp(rc);
        check("t4_data", rsp_data, 32'h40800000);
        s_data = rsp_data; s_status = rsp_status; s_id = rsp_id;
        for (int t = 0; t < 20; t++) begin
            tick(1);
            check("t4_hold", {rsp_valid, 3'b0, rsp_status, 6'b0, rsp_id, 16'b0},
                             {1'b1, 3'b0, s_status, 6'b0, s_id, 16'b0});
            check("t4_hold_data", rsp_data, s_data);
            check("t4_no_ready", {30'b0, busy, |req_ready}, 32'b10);
        end
        rsp_ready = 1'b1;
        rel = cyc;
        wait_grant(g, gc);
        req_valid[0] = 1'b0;
        check("t4_regrant_delay", 32'(gc - rel), 32'd2);
        check("t4_regrant_idx", 32'(g), 32'd0);
        tick(14);

        // Test 5: requester 2 withdraws before it is ever granted.
        reset_pulse();
        g2_cnt  = 0;
        id2_cnt = 0;
        req_valid = 4'b0110;
        wait_grant(g, gc);
        req_valid[1] = 1'b0;
        check("t5_first_grant", 32'(g), 32'd1);
        tick(3);
        req_valid[2] = 1'b0;
        tick(20);
        req_op_a[127:96] = 32'h3E000001;
        req_op_b[127:96] = 32'h3E000000;
        req_valid[3] = 1'b1;
        wait_grant(g, gc);
        req_valid[3] = 1'b0;
        check("t5_next_grant", 32'(g), 32'd3);
        wait_rsp(rc);
        check("t5_inexact_data", rsp_data, 32'h40000000);
        check("t5_inexact_status", 32'(rsp_status), 32'b0010);
        tick(3);
        check("t5_req2_grants", 32'(g2_cnt), 32'd0);
        check("t5_id2_seen", 32'(id2_cnt), 32'd0);

        // Test 6: non-one-hot status from the FPU flags an error.
        force_bad    = 1'b1;
        rsp_ready    = 1'b0;
        req_valid[0] = 1'b1;
        wait_grant(g, gc);
        req_valid[0] = 1'b0;
        wait_rsp(rc);
        check("t6_err", 32'(rsp_err), 32'd1);
        check("t6_status", 32'(rsp_status), 32'b0011);
        rsp_ready = 1'b1;
        tick(1);
        check("t6_err_cleared", 32'(rsp_err), 32'd0);
        check("t6_valid_cleared", 32'(rsp_valid), 32'd0);
        force_bad = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
